// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus a memory-mapped timer/tohost block.
// Read data is combinational; all state updates on the rising clock edge.
module dmem_responder #(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_a_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        bus_err_o,
  output logic        timer_irq_o,
  output logic [31:0] tohost_o,
  output logic        tohost_valid_o
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) << 2;

  localparam logic [3:0] OFF_MTIME_LO = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI = 4'h1;
  localparam logic [3:0] OFF_CMP_LO   = 4'h2;
  localparam logic [3:0] OFF_CMP_HI   = 4'h3;
  localparam logic [3:0] OFF_TOHOST   = 4'h4;

  logic [31:0] ram [RAM_DEPTH];

  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] widx;
  logic [3:0]    reg_off;
  logic          wr;
  logic          ram_we;
  logic          wr_mtime_lo;
  logic          wr_mtime_hi;
  logic          wr_cmp_lo;
  logic          wr_cmp_hi;
  logic          wr_tohost;
  logic          tick;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [63:0]   mtime;
  logic [63:0]   mtime_nxt;
  logic [63:0]   mtimecmp;
  logic [31:0]   rdata;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode
  assign ram_hit   = {1'b0, mem_a_i} < RAM_BYTES;
  assign mmio_hit  = !ram_hit && (mem_a_i[31:6] == MMIO_BASE[31:6]);
  assign widx      = mem_a_i[AW+1:2];
  assign reg_off   = mem_a_i[5:2];
  assign bus_err_o = mem_ce_i & ~ram_hit & ~mmio_hit;

  assign wr          = mem_ce_i & mem_we_i;
  assign ram_we      = wr & ram_hit & n_rst_i;
  assign wr_mtime_lo = wr & mmio_hit & (reg_off == OFF_MTIME_LO);
  assign wr_mtime_hi = wr & mmio_hit & (reg_off == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr & mmio_hit & (reg_off == OFF_CMP_LO);
  assign wr_cmp_hi   = wr & mmio_hit & (reg_off == OFF_CMP_HI);
  assign wr_tohost   = wr & mmio_hit & (reg_off == OFF_TOHOST);

  // Read mux; unmapped offsets and non-read cycles return zero
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[widx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_MTIME_LO: rdata = mtime[31:0];
        OFF_MTIME_HI: rdata = mtime[63:32];
        OFF_CMP_LO:   rdata = mtimecmp[31:0];
        OFF_CMP_HI:   rdata = mtimecmp[63:32];
        OFF_TOHOST:   rdata = tohost_o;
        default:      rdata = '0;
      endcase
    end
  end

  assign mem_data_o = (n_rst_i && mem_ce_i && !mem_we_i) ? rdata : '0;

  // RAM storage is not reset; writes are dropped while reset is asserted
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel_i[b]) ram[widx][8*b +: 8] <= mem_data_i[8*b +: 8];
      end
    end
  end

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign presc_nxt = tick ? '0 : presc + PW'(1);

  // A software write to either half suppresses the tick for the whole counter
  always_comb begin
    mtime_nxt = mtime;
    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_nxt[31:0]  = merge(mtime[31:0],  mem_data_i, mem_sel_i);
      if (wr_mtime_hi) mtime_nxt[63:32] = merge(mtime[63:32], mem_data_i, mem_sel_i);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      presc          <= '0;
      mtime          <= '0;
      mtimecmp       <= '1;
      timer_irq_o    <= 1'b0;
      tohost_o       <= '0;
      tohost_valid_o <= 1'b0;
    end else begin
      presc          <= presc_nxt;
      mtime          <= mtime_nxt;
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  mem_data_i, mem_sel_i);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_data_i, mem_sel_i);
      timer_irq_o    <= (mtime >= mtimecmp);
      tohost_valid_o <= wr_tohost;
      if (wr_tohost) tohost_o <= merge(tohost_o, mem_data_i, mem_sel_i);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a queue of expected results.
// Two instances share stimulus: TICK_DIV=1 and TICK_DIV=4.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h0200_0000;

  logic        clk;
  logic        n_rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;

  logic [31:0] data1, data4;
  logic        berr1, berr4;
  logic        irq1, irq4;
  logic [31:0] th1, th4;
  logic        thv1, thv4;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(.RAM_DEPTH(4096), .MMIO_BASE(MB), .TICK_DIV(1)) u_dut (
    .clk_i(clk), .n_rst_i(n_rst), .mem_ce_i(ce), .mem_we_i(we), .mem_a_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(data1), .bus_err_o(berr1),
    .timer_irq_o(irq1), .tohost_o(th1), .tohost_valid_o(thv1)
  );

  dmem_responder #(.RAM_DEPTH(4096), .MMIO_BASE(MB), .TICK_DIV(4)) u_dut4 (
    .clk_i(clk), .n_rst_i(n_rst), .mem_ce_i(ce), .mem_we_i(we), .mem_a_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(data4), .bus_err_o(berr4),
    .timer_irq_o(irq4), .tohost_o(th4), .tohost_valid_o(thv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mtime for the TICK_DIV=1 instance: edges since reset release
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h expected queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'h0; wdata = '0;
    #1;
  endtask

  task automatic do_idle();
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = '0; sel = 4'h0; wdata = '0;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    n_rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    #1;
    expect_val("rst_irq", 32'h0);      check({31'b0, irq1});
    expect_val("rst_tohost", 32'h0);   check(th1);
    expect_val("rst_valid", 32'h0);    check({31'b0, thv1});
    expect_val("rst_data", 32'h0);     check(data1);
    expect_val("rst_irq4", 32'h0);     check({31'b0, irq4});
    expect_val("rst_tohost4", 32'h0);  check(th4);
    expect_val("rst_valid4", 32'h0);   check({31'b0, thv4});
    expect_val("rst_data4", 32'h0);    check(data4);

    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Timer compare at 20, then raise compare above mtime
    do_write(MB + 32'h0C, 32'h0, 4'hF);
    do_write(MB + 32'h08, 32'd20, 4'hF);
    for (int i = 0; i < 28; i++) begin
      do_read(MB + 32'h00);
      expect_val("mtime_lo", 32'(cyc));          check(data1);
      expect_val("mtime_lo_div4", 32'(cyc / 4)); check(data4);
      expect_val("irq_cmp", (cyc >= 21) ? 32'h1 : 32'h0);
      check({31'b0, irq1});
    end
    do_write(MB + 32'h08, 32'hFFFF_FFFF, 4'hF);
    do_idle();
    expect_val("irq_hold", 32'h1);   check({31'b0, irq1});
    do_idle();
    expect_val("irq_fall", 32'h0);   check({31'b0, irq1});

    // RAM byte lanes
    do_write(32'h100, 32'h1122_3344, 4'hF);
    do_write(32'h101, 32'hAAAA_AAAA, 4'b0010);
    do_write(32'h102, 32'hBEEF_BEEF, 4'b1100);
    do_read(32'h100);
    expect_val("ram_lanes", 32'hBEEF_AA44); check(data1);

    // Read-after-write and empty byte select
    do_write(32'h200, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h200);
    expect_val("raw", 32'hDEAD_BEEF); check(data1);
    do_write(32'h200, 32'h0, 4'h0);
    do_read(32'h200);
    expect_val("sel_zero", 32'hDEAD_BEEF); check(data1);

    // Unmapped access
    do_write(32'h0, 32'hCAFE_F00D, 4'hF);
    do_read(32'h0100_0000);
    expect_val("unmap_rd_data", 32'h0); check(data1);
    expect_val("unmap_rd_err", 32'h1);  check({31'b0, berr1});
    expect_val("unmap_rd_err4", 32'h1); check({31'b0, berr4});
    do_write(32'h0100_0000, 32'h1234_5678, 4'hF);
    expect_val("unmap_wr_err", 32'h1);  check({31'b0, berr1});
    do_read(32'h0);
    expect_val("unmap_ram_kept", 32'hCAFE_F00D); check(data1);
    expect_val("mapped_no_err", 32'h0);          check({31'b0, berr1});

    // Reserved register offset
    do_write(MB + 32'h20, 32'hFFFF_FFFF, 4'hF);
    do_read(MB + 32'h20);
    expect_val("rsvd_data", 32'h0); check(data1);
    expect_val("rsvd_err", 32'h0);  check({31'b0, berr1});

    // tohost pulses
    do_write(MB + 32'h10, 32'h1, 4'hF);
    do_idle();
    expect_val("tohost_val", 32'h1);   check(th1);
    expect_val("tohost_pulse", 32'h1); check({31'b0, thv1});
    do_idle();
    expect_val("tohost_pulse_end", 32'h0); check({31'b0, thv1});
    do_write(MB + 32'h10, 32'h2, 4'hF);
    do_write(MB + 32'h10, 32'h3, 4'hF);
    expect_val("b2b_val1", 32'h2);   check(th1);
    expect_val("b2b_pulse1", 32'h1); check({31'b0, thv1});
    do_idle();
    expect_val("b2b_val2", 32'h3);   check(th1);
    expect_val("b2b_pulse2", 32'h1); check({31'b0, thv1});
    do_idle();
    expect_val("b2b_end", 32'h0);    check({31'b0, thv1});

    // Write/tick collision on the divide-by-4 instance
    for (int i = 0; i < 4 && (cyc % 4) != 2; i++) @(negedge clk);
    do_write(MB + 32'h00, 32'd5, 4'hF);
    do_read(MB + 32'h00);
    expect_val("collide_lo", 32'd5); check(data4);
    repeat (3) do_idle();
    do_read(MB + 32'h00);
    expect_val("collide_next_tick", 32'd6); check(data4);

    // 64-bit carry on the divide-by-1 instance
    do_write(MB + 32'h04, 32'h0, 4'hF);
    do_write(MB + 32'h00, 32'hFFFF_FFFE, 4'hF);
    do_read(MB + 32'h00);
    expect_val("carry_lo0", 32'hFFFF_FFFE); check(data1);
    do_read(MB + 32'h00);
    expect_val("carry_lo1", 32'hFFFF_FFFF); check(data1);
    do_read(MB + 32'h00);
    expect_val("carry_lo2", 32'h0); check(data1);
    do_read(MB + 32'h04);
    expect_val("carry_hi", 32'h1);  check(data1);

    // Reset in the middle of a write and a tick
    do_write(32'h300, 32'h1234_5678, 4'hF);
    do_idle();
    expect_val("pre_rst_irq", 32'h1); check({31'b0, irq1});
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'hFFFF_FFFF; sel = 4'hF;
    #2 n_rst = 1'b0;
    #1;
    expect_val("mid_rst_irq", 32'h0);    check({31'b0, irq1});
    expect_val("mid_rst_tohost", 32'h0); check(th1);
    expect_val("mid_rst_valid", 32'h0);  check({31'b0, thv1});
    @(negedge clk);
    we = 1'b0;
    #1;
    expect_val("mid_rst_data", 32'h0);   check(data1);
    @(negedge clk);
    n_rst = 1'b1;
    do_read(32'h300);
    expect_val("rst_write_dropped", 32'h1234_5678); check(data1);
    do_read(MB + 32'h00);
    expect_val("post_rst_mtime", 32'(cyc)); check(data1);
    repeat (4) do_idle();
    expect_val("post_rst_irq", 32'h0); check({31'b0, irq1});

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
